// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types and glyphs for the seven-segment status display.
//   state_e     - run status of the display controller
//   SEG_*       - active-low segment patterns, bit 6 = segment g ... bit 0 = segment a
//   bcd_to_seg  - BCD digit to segment pattern, dark for codes above 9
package seg7_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GO    = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_e;

   localparam logic [6:0] SEG_DARK = 7'b1111111;
   localparam logic [6:0] SEG_DASH = 7'b0111111;

   localparam logic [6:0] SEG_0 = 7'b1000000;
   localparam logic [6:0] SEG_1 = 7'b1111001;
   localparam logic [6:0] SEG_2 = 7'b0100100;
   localparam logic [6:0] SEG_3 = 7'b0110000;
   localparam logic [6:0] SEG_4 = 7'b0011001;
   localparam logic [6:0] SEG_5 = 7'b0010010;
   localparam logic [6:0] SEG_6 = 7'b0000010;
   localparam logic [6:0] SEG_7 = 7'b1011000;
   localparam logic [6:0] SEG_8 = 7'b0000000;
   localparam logic [6:0] SEG_9 = 7'b0010000;

   localparam logic [6:0] SEG_P = 7'b0001100;
   localparam logic [6:0] SEG_A = 7'b0001000;
   localparam logic [6:0] SEG_U = 7'b1000001;
   localparam logic [6:0] SEG_S = 7'b0010010;
   localparam logic [6:0] SEG_E = 7'b0000110;
   localparam logic [6:0] SEG_D = 7'b0100001;
   localparam logic [6:0] SEG_O = 7'b0100011;
   localparam logic [6:0] SEG_N = 7'b0101011;

   function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
      logic [6:0] seg;
      case (d)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_DARK;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/seg7_status_display_if.sv
// seg7_status_display_if: value handshake between the value producer and the display.
//   value_i        - binary value offered
//   value_valid_i  - value_i is offered
//   value_ready_o  - converter can accept a value
// Signal suffixes are from the display's point of view (slave modport).
interface seg7_status_display_if #(
   parameter int unsigned VALUE_W = 17
);
   logic [VALUE_W-1:0] value_i;
   logic               value_valid_i;
   logic               value_ready_o;

   modport master (
      output value_i,
      output value_valid_i,
      input  value_ready_o
   );

   modport slave (
      input  value_i,
      input  value_valid_i,
      output value_ready_o
   );
endinterface

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary to BCD converter.
//   clk, rst  - clock, asynchronous active-high reset
//   valid_i   - bin_i offered; accepted when ready_o is high
//   ready_o   - idle, can accept a value
//   bin_i     - unsigned binary input, captured on accept
//   bcd_o     - NUM_BCD packed BCD digits, digit 0 in bits [3:0]
//   done_o    - one-cycle pulse, bcd_o holds the finished result
// The accept edge is the load cycle; VALUE_W shift/add-3 cycles follow, then one
// cycle with done_o high before ready_o returns.
module bin2bcd_seq #(
   parameter int unsigned VALUE_W = 17,
   parameter int unsigned NUM_BCD = 9
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   valid_i,
   output logic                   ready_o,
   input  logic [VALUE_W-1:0]     bin_i,
   output logic [4*NUM_BCD-1:0]   bcd_o,
   output logic                   done_o
);

   localparam int unsigned CntW = $clog2(VALUE_W + 1);
   localparam logic [CntW-1:0] LastCnt = CntW'(VALUE_W);

   logic                         busy_q, busy_d;
   logic [CntW-1:0]              cnt_q, cnt_d;
   logic [VALUE_W-1:0]           bin_q, bin_d;
   logic [4*NUM_BCD-1:0]         bcd_q, bcd_d;
   logic [4*NUM_BCD-1:0]         adj;
   logic [4*NUM_BCD+VALUE_W-1:0] shifted;

   // Add 3 to every digit >= 5, then shift the whole {bcd, bin} pair left by one.
   always_comb begin
      adj = bcd_q;
      for (int i = 0; i < NUM_BCD; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) begin
            adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
         end
      end
      shifted = {adj, bin_q} << 1;
   end

   always_comb begin
      busy_d = busy_q;
      cnt_d  = cnt_q;
      bin_d  = bin_q;
      bcd_d  = bcd_q;
      if (!busy_q) begin
         if (valid_i) begin
            busy_d = 1'b1;
            cnt_d  = '0;
            bin_d  = bin_i;
            bcd_d  = '0;
         end
      end else if (cnt_q == LastCnt) begin
         busy_d = 1'b0;
      end else begin
         bcd_d = shifted[4*NUM_BCD+VALUE_W-1:VALUE_W];
         bin_d = shifted[VALUE_W-1:0];
         cnt_d = cnt_q + CntW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
         bin_q  <= '0;
         bcd_q  <= '0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
         bin_q  <= bin_d;
         bcd_q  <= bcd_d;
      end
   end

   assign ready_o = ~busy_q;
   assign done_o  = busy_q && (cnt_q == LastCnt);
   assign bcd_o   = bcd_q;

endmodule

// File: rtl/seg7_status_display.sv
// seg7_status_display: run-status seven-segment controller for the HEX bank.
//   clk, rst    - clock, asynchronous active-high reset
//   start_i     - pulse, IDLE -> GO
//   pause_i     - pulse, toggles GO <-> PAUSE (wins over finish_i)
//   finish_i    - pulse, GO -> DONE (sticky until reset)
//   val_if      - value/valid/ready handshake feeding the BCD converter
//   blank_lz_i  - blank leading zeros of the numeric display
//   hex_o       - registered active-low segments, digit k in [7k+6:7k]
//   busy_o      - conversion in progress
module seg7_status_display
   import seg7_pkg::*;
#(
   parameter int unsigned NUM_DIGITS = 8,
   parameter int unsigned VALUE_W    = 17,
   parameter int unsigned BLINK_CYC  = 25_000_000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start_i,
   input  logic                    pause_i,
   input  logic                    finish_i,
   seg7_status_display_if.slave    val_if,
   input  logic                    blank_lz_i,
   output logic [7*NUM_DIGITS-1:0] hex_o,
   output logic                    busy_o
);

   localparam int unsigned NumBcd = NUM_DIGITS + 1;
   localparam int unsigned BlinkW = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
   localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_CYC - 1);

   state_e                  state_q, state_d;
   logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
   logic                    ovf_q, ovf_d;
   logic [BlinkW-1:0]       blink_cnt_q, blink_cnt_d;
   logic                    blink_dark_q, blink_dark_d;
   logic [7*NUM_DIGITS-1:0] hex_q, hex_d;

   logic                    conv_ready;
   logic                    conv_done;
   logic [4*NumBcd-1:0]     conv_bcd;
   logic                    lead;
   logic [3:0]              dig;

   bin2bcd_seq #(
      .VALUE_W (VALUE_W),
      .NUM_BCD (NumBcd)
   ) u_bin2bcd (
      .clk     (clk),
      .rst     (rst),
      .valid_i (val_if.value_valid_i),
      .ready_o (conv_ready),
      .bin_i   (val_if.value_i),
      .bcd_o   (conv_bcd),
      .done_o  (conv_done)
   );

   assign val_if.value_ready_o = conv_ready;
   assign busy_o               = ~conv_ready;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_i) state_d = GO;
         GO: begin
            if (pause_i)       state_d = PAUSE;
            else if (finish_i) state_d = DONE;
         end
         PAUSE:   if (pause_i) state_d = GO;
         default: state_d = state_q;
      endcase
   end

   // Result and overflow flag land together so the display never mixes two values.
   always_comb begin
      disp_d = disp_q;
      ovf_d  = ovf_q;
      if (conv_done) begin
         disp_d = conv_bcd[4*NUM_DIGITS-1:0];
         ovf_d  = |conv_bcd[4*NUM_DIGITS +: 4];
      end
   end

   // Held at zero outside PAUSE so each entry starts with the message visible.
   always_comb begin
      blink_cnt_d  = '0;
      blink_dark_d = 1'b0;
      if (state_q == PAUSE) begin
         blink_dark_d = blink_dark_q;
         if (blink_cnt_q == BlinkLast) begin
            blink_cnt_d  = '0;
            blink_dark_d = ~blink_dark_q;
         end else begin
            blink_cnt_d = blink_cnt_q + BlinkW'(1);
         end
      end
   end

   always_comb begin
      hex_d = {NUM_DIGITS{SEG_DARK}};
      lead  = 1'b1;
      dig   = '0;
      case (state_q)
         IDLE: hex_d = {NUM_DIGITS{SEG_DASH}};
         GO: begin
            // Walk from the top digit down; lead stays set until a nonzero digit.
            for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
               dig = disp_q[4*k +: 4];
               if (dig != 4'd0) lead = 1'b0;
               if (ovf_q)                             hex_d[7*k +: 7] = SEG_E;
               else if (blank_lz_i && lead && k != 0) hex_d[7*k +: 7] = SEG_DARK;
               else                                   hex_d[7*k +: 7] = bcd_to_seg(dig);
            end
         end
         PAUSE: begin
            if (!blink_dark_q) hex_d[34:0] = {SEG_P, SEG_A, SEG_U, SEG_S, SEG_E};
         end
         default: hex_d[27:0] = {SEG_D, SEG_O, SEG_N, SEG_E};
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         disp_q       <= '0;
         ovf_q        <= 1'b0;
         blink_cnt_q  <= '0;
         blink_dark_q <= 1'b0;
         hex_q        <= {NUM_DIGITS{SEG_DASH}};
      end else begin
         state_q      <= state_d;
         disp_q       <= disp_d;
         ovf_q        <= ovf_d;
         blink_cnt_q  <= blink_cnt_d;
         blink_dark_q <= blink_dark_d;
         hex_q        <= hex_d;
      end
   end

   assign hex_o = hex_q;

endmodule

// File: tb/tb_seg7_status_display.sv
// tb_seg7_status_display: randomized self-checking bench for seg7_status_display.
// Two instances share all stimulus: an 8-digit one and a 5-digit one (for overflow).
// Expected segment patterns come from decimal arithmetic on the offered values.
module tb_seg7_status_display;

   localparam int S_IDLE  = 0;
   localparam int S_GO    = 1;
   localparam int S_PAUSE = 2;
   localparam int S_DONE  = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start_i = 1'b0;
   logic        pause_i = 1'b0;
   logic        finish_i = 1'b0;
   logic        blank_lz_i = 1'b0;
   logic [55:0] hex8;
   logic [34:0] hex5;
   logic        busy8, busy5;

   int n_pass = 0;
   int n_tot  = 0;
   int m_val  = 0;

   always #5 clk = ~clk;

   seg7_status_display_if #(.VALUE_W(17)) bus8 ();
   seg7_status_display_if #(.VALUE_W(17)) bus5 ();

   seg7_status_display #(.NUM_DIGITS(8), .VALUE_W(17), .BLINK_CYC(4)) dut8 (
      .clk(clk), .rst(rst), .start_i(start_i), .pause_i(pause_i), .finish_i(finish_i),
      .val_if(bus8), .blank_lz_i(blank_lz_i), .hex_o(hex8), .busy_o(busy8)
   );

   seg7_status_display #(.NUM_DIGITS(5), .VALUE_W(17), .BLINK_CYC(4)) dut5 (
      .clk(clk), .rst(rst), .start_i(start_i), .pause_i(pause_i), .finish_i(finish_i),
      .val_if(bus5), .blank_lz_i(blank_lz_i), .hex_o(hex5), .busy_o(busy5)
   );

   function automatic int pow10(input int n);
      int p = 1;
      for (int i = 0; i < n; i++) p = p * 10;
      return p;
   endfunction

   function automatic logic [6:0] seg_of(input int d);
      case (d)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1011000;
         8: return 7'b0000000;
         9: return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   // Expected bank for an nd-digit display; digits at or above nd stay dark.
   function automatic logic [55:0] exp_hex(input int st, input int v, input bit blank,
                                           input bit dark, input int nd);
      logic [55:0] e;
      int msd;
      int d;
      e = {8{7'b1111111}};
      case (st)
         S_IDLE: for (int k = 0; k < nd; k++) e[7*k +: 7] = 7'b0111111;
         S_GO: begin
            if (v >= pow10(nd)) begin
               for (int k = 0; k < nd; k++) e[7*k +: 7] = 7'b0000110;
            end else begin
               msd = 0;
               for (int k = 0; k < nd; k++) if ((v / pow10(k)) % 10 != 0) msd = k;
               for (int k = 0; k < nd; k++) begin
                  d = (v / pow10(k)) % 10;
                  if (!(blank && k > msd)) e[7*k +: 7] = seg_of(d);
               end
            end
         end
         S_PAUSE: begin
            if (!dark) e[34:0] = {7'b0001100, 7'b0001000, 7'b1000001, 7'b0010010, 7'b0000110};
         end
         default: e[27:0] = {7'b0100001, 7'b0100011, 7'b0101011, 7'b0000110};
      endcase
      return e;
   endfunction

   task automatic drive_val(input int v, input bit valid);
      bus8.value_i = 17'(v);
      bus5.value_i = 17'(v);
      bus8.value_valid_i = valid;
      bus5.value_valid_i = valid;
   endtask

   task automatic test_reset();
      logic [55:0] e8, t;
      e8 = exp_hex(S_IDLE, 0, 0, 0, 8);
      t  = exp_hex(S_IDLE, 0, 0, 0, 5);
      n_tot++; if (hex8 !== e8) $display("FAIL reset_hex8 got %h exp %h", hex8, e8);
               else n_pass++;
      n_tot++; if (hex5 !== t[34:0]) $display("FAIL reset_hex5 got %h exp %h", hex5, t[34:0]);
               else n_pass++;
      n_tot++; if (bus8.value_ready_o !== 1'b1 || bus5.value_ready_o !== 1'b1)
                  $display("FAIL reset_ready got %b%b exp 11", bus8.value_ready_o,
                           bus5.value_ready_o);
               else n_pass++;
      n_tot++; if (busy8 !== 1'b0 || busy5 !== 1'b0)
                  $display("FAIL reset_busy got %b%b exp 00", busy8, busy5);
               else n_pass++;
   endtask

   task automatic test_start();
      logic [55:0] e8, t;
      blank_lz_i = 1'b0;
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      e8 = exp_hex(S_IDLE, 0, 0, 0, 8);
      n_tot++; if (hex8 !== e8) $display("FAIL start_latency got %h exp %h", hex8, e8);
               else n_pass++;
      @(negedge clk);
      e8 = exp_hex(S_GO, 0, 0, 0, 8);
      t  = exp_hex(S_GO, 0, 0, 0, 5);
      n_tot++; if (hex8 !== e8) $display("FAIL start_zeros8 got %h exp %h", hex8, e8);
               else n_pass++;
      n_tot++; if (hex5 !== t[34:0]) $display("FAIL start_zeros5 got %h exp %h", hex5, t[34:0]);
               else n_pass++;
   endtask

   // Offer v in GO and check ready/busy timing plus the old and new displays.
   task automatic test_value(input int v, input bit b);
      logic [55:0] eo8, en8, t;
      logic [34:0] eo5, en5;
      int low8, low5;
      blank_lz_i = b;
      eo8 = exp_hex(S_GO, m_val, b, 0, 8);
      t = exp_hex(S_GO, m_val, b, 0, 5); eo5 = t[34:0];
      en8 = exp_hex(S_GO, v, b, 0, 8);
      t = exp_hex(S_GO, v, b, 0, 5); en5 = t[34:0];
      drive_val(v, 1'b1);
      @(negedge clk);
      drive_val(int'($urandom_range(0, 131071)), 1'b0);
      low8 = 0;
      low5 = 0;
      for (int i = 0; i < 18; i++) begin
         if (!bus8.value_ready_o && busy8) low8++;
         if (!bus5.value_ready_o && busy5) low5++;
         @(negedge clk);
      end
      n_tot++; if (low8 != 18 || low5 != 18)
                  $display("FAIL value_busy_cycles v=%0d got %0d/%0d exp 18", v, low8, low5);
               else n_pass++;
      n_tot++; if (bus8.value_ready_o !== 1'b1 || bus5.value_ready_o !== 1'b1)
                  $display("FAIL value_ready_return v=%0d got %b%b exp 11", v,
                           bus8.value_ready_o, bus5.value_ready_o);
               else n_pass++;
      n_tot++; if (hex8 !== eo8 || hex5 !== eo5)
                  $display("FAIL value_early v=%0d got %h/%h exp %h/%h", v, hex8, hex5, eo8, eo5);
               else n_pass++;
      @(negedge clk);
      n_tot++; if (hex8 !== en8) $display("FAIL value_hex8 v=%0d got %h exp %h", v, hex8, en8);
               else n_pass++;
      n_tot++; if (hex5 !== en5) $display("FAIL value_hex5 v=%0d got %h exp %h", v, hex5, en5);
               else n_pass++;
      m_val = v;
   endtask

   task automatic test_back_to_back(input int v1, input int v2);
      logic [55:0] e8, t;
      blank_lz_i = 1'b0;
      drive_val(v1, 1'b1);
      @(negedge clk);
      drive_val(v2, 1'b1);
      repeat (18) @(negedge clk);
      n_tot++; if (bus8.value_ready_o !== 1'b1)
                  $display("FAIL b2b_ready1 got %b exp 1", bus8.value_ready_o);
               else n_pass++;
      @(negedge clk);
      drive_val(0, 1'b0);
      e8 = exp_hex(S_GO, v1, 0, 0, 8);
      n_tot++; if (bus8.value_ready_o !== 1'b0)
                  $display("FAIL b2b_second_accept got %b exp 0", bus8.value_ready_o);
               else n_pass++;
      n_tot++; if (hex8 !== e8) $display("FAIL b2b_first got %h exp %h", hex8, e8);
               else n_pass++;
      repeat (19) @(negedge clk);
      e8 = exp_hex(S_GO, v2, 0, 0, 8);
      t  = exp_hex(S_GO, v2, 0, 0, 5);
      n_tot++; if (hex8 !== e8 || hex5 !== t[34:0])
                  $display("FAIL b2b_second got %h/%h exp %h/%h", hex8, hex5, e8, t[34:0]);
               else n_pass++;
      m_val = v2;
   endtask

   task automatic test_pause();
      logic [55:0] e8, t;
      int good8, good5;
      pause_i = 1'b1;
      finish_i = 1'b1;
      @(negedge clk);
      pause_i = 1'b0;
      finish_i = 1'b0;
      e8 = exp_hex(S_GO, m_val, blank_lz_i, 0, 8);
      n_tot++; if (hex8 !== e8) $display("FAIL pause_latency got %h exp %h", hex8, e8);
               else n_pass++;
      good8 = 0;
      good5 = 0;
      for (int j = 0; j < 22; j++) begin
         if (j == 9) begin
            finish_i = 1'b1;
            start_i = 1'b1;
         end
         @(negedge clk);
         finish_i = 1'b0;
         start_i = 1'b0;
         e8 = exp_hex(S_PAUSE, 0, 0, 1'((j / 4) % 2), 8);
         t  = exp_hex(S_PAUSE, 0, 0, 1'((j / 4) % 2), 5);
         if (hex8 === e8) good8++;
         if (hex5 === t[34:0]) good5++;
      end
      n_tot++; if (good8 != 22 || good5 != 22)
                  $display("FAIL pause_blink got %0d/%0d exp 22", good8, good5);
               else n_pass++;
      pause_i = 1'b1;
      @(negedge clk);
      pause_i = 1'b0;
      @(negedge clk);
      e8 = exp_hex(S_GO, m_val, blank_lz_i, 0, 8);
      n_tot++; if (hex8 !== e8) $display("FAIL pause_resume got %h exp %h", hex8, e8);
               else n_pass++;
      pause_i = 1'b1;
      @(negedge clk);
      pause_i = 1'b0;
      @(negedge clk);
      e8 = exp_hex(S_PAUSE, 0, 0, 0, 8);
      n_tot++; if (hex8 !== e8) $display("FAIL pause_reentry got %h exp %h", hex8, e8);
               else n_pass++;
      pause_i = 1'b1;
      @(negedge clk);
      pause_i = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_done();
      logic [55:0] e8, t;
      int good, low;
      finish_i = 1'b1;
      @(negedge clk);
      finish_i = 1'b0;
      @(negedge clk);
      e8 = exp_hex(S_DONE, 0, 0, 0, 8);
      t  = exp_hex(S_DONE, 0, 0, 0, 5);
      n_tot++; if (hex8 !== e8 || hex5 !== t[34:0])
                  $display("FAIL done_msg got %h/%h exp %h/%h", hex8, hex5, e8, t[34:0]);
               else n_pass++;
      start_i = 1'b1;
      pause_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      pause_i = 1'b0;
      drive_val(int'($urandom_range(1, 99999)), 1'b1);
      @(negedge clk);
      drive_val(0, 1'b0);
      good = 0;
      low = 0;
      for (int i = 0; i < 20; i++) begin
         if (hex8 === e8) good++;
         if (!bus8.value_ready_o) low++;
         @(negedge clk);
      end
      n_tot++; if (good != 20) $display("FAIL done_sticky got %0d exp 20", good);
               else n_pass++;
      n_tot++; if (low != 18) $display("FAIL done_handshake got %0d exp 18", low);
               else n_pass++;
   endtask

   task automatic test_reset_abort();
      logic [55:0] e8, t;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      m_val = 0;
      blank_lz_i = 1'b1;
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      drive_val(int'($urandom_range(1, 131071)), 1'b1);
      @(negedge clk);
      drive_val(0, 1'b0);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      #1;
      e8 = exp_hex(S_IDLE, 0, 0, 0, 8);
      n_tot++; if (bus8.value_ready_o !== 1'b1 || busy8 !== 1'b0)
                  $display("FAIL abort_handshake got ready=%b busy=%b exp 1/0",
                           bus8.value_ready_o, busy8);
               else n_pass++;
      n_tot++; if (hex8 !== e8) $display("FAIL abort_dashes got %h exp %h", hex8, e8);
               else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      repeat (20) @(negedge clk);
      e8 = exp_hex(S_GO, 0, 1, 0, 8);
      t  = exp_hex(S_GO, 0, 1, 0, 5);
      n_tot++; if (hex8 !== e8 || hex5 !== t[34:0])
                  $display("FAIL abort_zero got %h/%h exp %h/%h", hex8, hex5, e8, t[34:0]);
               else n_pass++;
   endtask

   initial begin
      drive_val(0, 1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      test_reset();
      test_start();
      test_value(12345, 1'b1);
      test_value(131071, 1'b0);
      test_value(99999, 1'b0);
      test_value(0, 1'b1);
      test_value(100000, 1'b1);
      test_value(7, 1'b1);
      for (int i = 0; i < 6; i++) begin
         test_value(int'($urandom_range(0, 131071)), 1'($urandom_range(0, 1)));
      end
      test_back_to_back(int'($urandom_range(0, 131071)), int'($urandom_range(0, 99999)));
      test_pause();
      test_done();
      test_reset_abort();
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
